otter_io_timer: RTL and testbench

OTTER_IO_TIMER -- requirements
Module: otter_io_timer

---
 rtl/otter_io_timer.sv | 119 +++++++++++
 tb/tb_otter_io_timer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_io_timer.sv
// OTTER memory-mapped timer: CTRL/COUNT/COMPARE/STATUS/PRESC word registers on the IO bus.
// Define OTTER_TIMER_PRESCALER_EN to build the 8-bit prescaler; otherwise the timer ticks every clock.
module otter_io_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] iobus_in,
  output logic        intrpt
);

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_COUNT   = 3'd1,
    REG_COMPARE = 3'd2,
    REG_STATUS  = 3'd3,
    REG_PRESC   = 3'd4
  } reg_sel_e;

  logic [31:0] offset;
  logic        hit;
  reg_sel_e    reg_sel;

  logic [2:0]  ctrl;
  logic [31:0] count;
  logic [31:0] compare;
  logic        match;
  logic        ovf;
  logic [7:0]  presc_rd;
  logic        tick;

  logic wr_ctrl, wr_count, wr_compare, wr_status, wr_presc;
  logic match_set, ovf_set, reload;

  assign offset  = iobus_addr - BASE_ADDR;
  assign hit     = (iobus_addr[31:5] == BASE_ADDR[31:5]) && (iobus_addr[1:0] == 2'b00)
                   && (offset <= 32'h10);
  assign reg_sel = reg_sel_e'(offset[4:2]);

  assign wr_ctrl    = iobus_wr && hit && (reg_sel == REG_CTRL);
  assign wr_count   = iobus_wr && hit && (reg_sel == REG_COUNT);
  assign wr_compare = iobus_wr && hit && (reg_sel == REG_COMPARE);
  assign wr_status  = iobus_wr && hit && (reg_sel == REG_STATUS);
  assign wr_presc   = iobus_wr && hit && (reg_sel == REG_PRESC);

`ifdef OTTER_TIMER_PRESCALER_EN
  logic [7:0] presc;
  logic [7:0] pcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      if (wr_presc)
        presc <= iobus_out[7:0];
      if (wr_ctrl || wr_presc || !ctrl[0] || (pcnt == presc))
        pcnt <= '0;
      else
        pcnt <= pcnt + 8'd1;
    end
  end

  assign tick     = ctrl[0] && (pcnt == presc);
  assign presc_rd = presc;
`else
  assign tick     = ctrl[0];
  assign presc_rd = '0;
`endif

  // A CPU write to COUNT suppresses both the increment and the compare for that edge.
  assign match_set = tick && !wr_count && (count == compare);
  assign reload    = match_set && ctrl[2];
  assign ovf_set   = tick && !wr_count && !reload && (count == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= '0;
      match   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl <= iobus_out[2:0];
      if (wr_compare)
        compare <= iobus_out;
      if (wr_count)
        count <= iobus_out;
      else if (reload)
        count <= '0;
      else if (tick)
        count <= count + 32'd1;
      // Hardware set wins over a same-edge write-1-to-clear.
      match <= match_set || (match && !(wr_status && iobus_out[0]));
      ovf   <= ovf_set   || (ovf   && !(wr_status && iobus_out[1]));
    end
  end

  always_comb begin
    iobus_in = '0;
    if (hit) begin
      case (reg_sel)
        REG_CTRL:    iobus_in = {29'd0, ctrl};
        REG_COUNT:   iobus_in = count;
        REG_COMPARE: iobus_in = compare;
        REG_STATUS:  iobus_in = {30'd0, ovf, match};
        REG_PRESC:   iobus_in = {24'd0, presc_rd};
        default:     iobus_in = '0;
      endcase
    end
  end

  assign intrpt = match && ctrl[1];

endmodule

// File: tb/tb_otter_io_timer.sv
// Randomized plus scenario bench for otter_io_timer against a cycle-level reference model.
module tb_otter_io_timer;

  localparam logic [31:0] BASE = 32'h1100_0200;
`ifdef OTTER_TIMER_PRESCALER_EN
  localparam bit PRESC_EN = 1'b1;
`else
  localparam bit PRESC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic        intrpt;

  always #5 clk = ~clk;

  otter_io_timer #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .iobus_addr(iobus_addr),
    .iobus_out (iobus_out),
    .iobus_wr  (iobus_wr),
    .iobus_in  (iobus_in),
    .intrpt    (intrpt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference model: register contents plus clocks elapsed since the prescaler last restarted.
  logic        m_run, m_ien, m_ar, m_match, m_ovf;
  logic [31:0] m_count, m_cmp;
  logic [7:0]  m_presc;
  int unsigned m_elapsed;

  task automatic model_reset();
    m_run = 0; m_ien = 0; m_ar = 0; m_match = 0; m_ovf = 0;
    m_count = 0; m_cmp = 0; m_presc = 0; m_elapsed = 0;
  endtask

  function automatic bit is_hit(input logic [31:0] a);
    return ((a >> 5) == (BASE >> 5)) && (a % 4 == 0) && ((a - BASE) <= 32'd16);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!is_hit(a)) return 32'd0;
    case (a - BASE)
      32'd0:   return {29'd0, m_ar, m_ien, m_run};
      32'd4:   return m_count;
      32'd8:   return m_cmp;
      32'd12:  return {30'd0, m_ovf, m_match};
      32'd16:  return {24'd0, m_presc};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bit h, w_ctrl, w_count, w_cmp, w_status, w_presc, tick, mset, oset;
    logic [31:0] off;
    h = is_hit(addr);
    off = addr - BASE;
    w_ctrl   = wr && h && off == 0;
    w_count  = wr && h && off == 4;
    w_cmp    = wr && h && off == 8;
    w_status = wr && h && off == 12;
    w_presc  = wr && h && off == 16;
    tick = m_run && (!PRESC_EN || (m_elapsed % (int'(m_presc) + 1) == int'(m_presc)));
    mset = 0; oset = 0;
    if (tick && !w_count) begin
      if (m_count == m_cmp) begin
        mset = 1;
        if (m_ar) m_count = 0;
        else begin oset = (m_count == 32'hFFFF_FFFF); m_count = m_count + 1; end
      end else begin
        oset = (m_count == 32'hFFFF_FFFF);
        m_count = m_count + 1;
      end
    end
    if (w_ctrl || w_presc || !m_run) m_elapsed = 0;
    else m_elapsed++;
    if (w_count) m_count = data;
    m_match = mset || (m_match && !(w_status && data[0]));
    m_ovf   = oset || (m_ovf && !(w_status && data[1]));
    if (w_ctrl) begin m_run = data[0]; m_ien = data[1]; m_ar = data[2]; end
    if (w_cmp) m_cmp = data;
    if (w_presc && PRESC_EN) m_presc = data[7:0];
  endtask

  // One bus clock: check combinational read, advance model and DUT, check outputs after the edge.
  task automatic bus_cycle(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    iobus_wr = wr; iobus_addr = addr; iobus_out = data;
    #1;
    check($sformatf("read_pre@%h", addr), iobus_in, model_read(addr));
    model_step(wr, addr, data);
    @(posedge clk); #1;
    check("intrpt", {31'd0, intrpt}, {31'd0, m_match && m_ien});
    check($sformatf("read_post@%h", addr), iobus_in, model_read(addr));
  endtask

  task automatic do_reset();
    rst = 0; iobus_wr = 1; iobus_addr = BASE + 4; iobus_out = 32'h55;
    model_reset();
    @(posedge clk); #1;
    check("reset_intrpt", {31'd0, intrpt}, 32'd0);
    for (int unsigned k = 0; k < 5; k++) begin
      iobus_addr = BASE + 4 * k;
      #1 check($sformatf("reset_reg%0d", k), iobus_in, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1;
  endtask

  // Asynchronous reset asserted mid-cycle with a write pending.
  task automatic mid_reset();
    #2;
    rst = 0; iobus_wr = 1; iobus_addr = BASE + 4; iobus_out = 32'hDEAD_BEEF;
    model_reset();
    #1;
    check("async_intrpt", {31'd0, intrpt}, 32'd0);
    check("async_count", iobus_in, 32'd0);
    @(posedge clk); #1;
    check("rst_wr_ignored", iobus_in, 32'd0);
    rst = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2: return BASE + 4 * $urandom_range(0, 4);
      3:       return BASE + 4 * $urandom_range(0, 4);
      4:       return BASE + 32'h14 + 4 * $urandom_range(0, 2);
      5:       return BASE + 32'h2 + 4 * $urandom_range(0, 3);
      6:       return BASE + 32'h100 + 4 * $urandom_range(0, 4);
      default: return BASE + 4 * $urandom_range(1, 3);
    endcase
  endfunction

  function automatic logic [31:0] rand_data(input logic [31:0] addr);
    case (addr - BASE)
      32'd0:  return ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      32'd4:  return ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                  : 32'($urandom_range(0, 12));
      32'd8:  return ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
      32'd16: return {$urandom_range(0, 1) == 0 ? 24'd0 : 24'($urandom), 8'($urandom_range(0, 3))};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit found;
    iobus_wr = 0; iobus_addr = 0; iobus_out = 0;
    do_reset();

    // Match with interrupt, then W1C.
    bus_cycle(1, BASE + 16, 0);
    bus_cycle(1, BASE + 8, 5);
    bus_cycle(1, BASE + 0, 3);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      bus_cycle(0, BASE + 4, 0);
      if (intrpt) begin
        found = 1;
        check("match_count6", iobus_in, 32'd6);
      end
    end
    check("match_seen", {31'd0, found}, 32'd1);
    bus_cycle(1, BASE + 12, 1);
    check("w1c_intrpt_low", {31'd0, intrpt}, 32'd0);

    // Auto-reload with prescaler.
    do_reset();
    bus_cycle(1, BASE + 16, 3);
    bus_cycle(1, BASE + 8, 2);
    bus_cycle(1, BASE + 0, 7);
    for (int i = 0; i < 26; i++) bus_cycle(0, BASE + ((i % 2 == 0) ? 4 : 12), 0);

    // Overflow without match.
    do_reset();
    bus_cycle(1, BASE + 4, 32'hFFFF_FFFF);
    bus_cycle(1, BASE + 8, 10);
    bus_cycle(1, BASE + 0, 1);
    bus_cycle(0, BASE + 12, 0);
    check("ovf_status", iobus_in, 32'h2);
    check("ovf_intrpt", {31'd0, intrpt}, 32'd0);
    bus_cycle(0, BASE + 4, 0);

    // Set beats W1C; COUNT write beats tick.
    do_reset();
    bus_cycle(1, BASE + 8, 3);
    bus_cycle(1, BASE + 0, 1);
    for (int i = 0; i < 3; i++) bus_cycle(0, BASE + 4, 0);
    bus_cycle(1, BASE + 12, 1);
    check("set_beats_w1c", {31'd0, iobus_in[0]}, 32'd1);
    bus_cycle(1, BASE + 4, 32'h1234);
    check("count_wr_wins", iobus_in, 32'h1234);
    bus_cycle(0, BASE + 4, 0);

    // Reset mid-count with interrupt pending, then out-of-range accesses.
    do_reset();
    bus_cycle(1, BASE + 8, 6);
    bus_cycle(1, BASE + 0, 3);
    for (int i = 0; i < 7; i++) bus_cycle(0, BASE + 4, 0);
    check("pre_rst_intrpt", {31'd0, intrpt}, 32'd1);
    mid_reset();
    bus_cycle(1, BASE + 32'h14, 32'hFFFF_FFFF);
    bus_cycle(1, BASE + 32'h02, 32'hFFFF_FFFF);
    for (int unsigned k = 0; k < 5; k++) bus_cycle(0, BASE + 4 * k, 0);

    // Prescale 2: tick every 3 clocks with the prescaler, every clock without.
    do_reset();
    bus_cycle(1, BASE + 16, 2);
    bus_cycle(1, BASE + 0, 1);
    for (int i = 0; i < 9; i++) bus_cycle(0, BASE + 4, 0);
    check("presc2_count", iobus_in, PRESC_EN ? 32'd3 : 32'd9);
    bus_cycle(0, BASE + 16, 0);
    check("presc2_read", iobus_in, PRESC_EN ? 32'd2 : 32'd0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 199) == 0) mid_reset();
      a = rand_addr();
      if ($urandom_range(0, 3) == 0) bus_cycle(1, a, rand_data(a));
      else bus_cycle(0, a, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
